palette_fader: RTL and testbench
================================

Name: palette_fader

Overview:
- Writable, parametrised colour palette for sprite and overlay layers, such as the game-over screen.
- Maps a pixel index to RGB through a 2-stage registered pipeline.
- Applies a global brightness level on top of the looked-up colour.
- A frame-synchronous sequencer drives the level for fade-in, fade-out and blink effects.
- Sits between the sprite ROM index output and the VGA colour mux; the game FSM owns palette writes and fade control.

Parameters:
- INDEX_W, 4: palette index width; the palette has 2^INDEX_W entries.
- CH_W, 4: bits per colour channel.
- STEP_FRAMES, 4: frame_start pulses per fade step or blink half-period, 1..255.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at the start of each frame (vsync edge).
- pix_valid  in  1  index is valid this cycle.
- index  in  INDEX_W  palette index to look up.
- wr_en  in  1  palette write strobe.
- wr_index  in  INDEX_W  entry to write.
- wr_color  in  3*CH_W  {r,g,b} value to write.
- fade_mode  in  2  00 none, 01 fade-in, 10 fade-out, 11 blink.
- fade_start  in  1  pulse; latches fade_mode and starts the effect.
- red, green, blue  out  CH_W each  scaled colour.
- out_valid  out  1  pix_valid delayed 2 cycles.
- transparent  out  1  1 when the delayed index was 0.
- busy  out  1  high in FADE_IN, FADE_OUT or BLINK.
- fade_done  out  1  one-cycle pulse when a fade-in or fade-out completes.

Behaviour:
- Reset values, applied on the clock edge:
  - red/green/blue = 0; out_valid, transparent, busy and fade_done = 0.
  - level = 2^CH_W (full brightness); state = IDLE; frame counter = 0.
  - Palette returns to defaults: entry 0 = black, all other entries = {max,0,0} (full red).
- Reset mid-fade aborts the fade; no fade_done is emitted.
- Latency: exactly 2 cycles from index/pix_valid to outputs.
  - Stage 1 reads the palette.
  - Stage 2 applies scaling.
  - Outputs update every cycle regardless of pix_valid; out_valid qualifies them.
- Scaling rule:
  - level is CH_W+1 bits, range 0..2^CH_W.
  - out_c = (c * level) >> CH_W, truncated.
  - level = 2^CH_W gives out = c exactly; level 0 gives 0.
  - Stage 2 uses the level value at the time the pixel enters stage 2.
- Writes:
  - Single write port, one entry per cycle, takes effect at the clock edge.
  - A read of the same index in the same cycle returns the old value; the new value is visible to reads starting the next cycle.
- State machine (IDLE, FADE_IN, FADE_OUT, BLINK):
  - fade_start with mode 01: level = 0, frame counter = 0, go to FADE_IN.
  - fade_start with mode 10: level = 2^CH_W, frame counter = 0, go to FADE_OUT.
  - fade_start with mode 11: level = 2^CH_W, frame counter = 0, go to BLINK.
  - fade_start with mode 00: level = 2^CH_W, go to IDLE from any state; no fade_done.
  - Frame counting: in a non-IDLE state, each frame_start increments the frame counter. When the counter reaches STEP_FRAMES it clears and one step occurs.
  - FADE_IN step: level += 1. When level reaches 2^CH_W, go to IDLE and pulse fade_done in the same cycle.
  - FADE_OUT step: level -= 1. When level reaches 0, go to IDLE and pulse fade_done. level stays 0 in IDLE until the next fade_start or Reset.
  - BLINK step: level toggles between 2^CH_W and 0. BLINK runs until fade_start or Reset.
  - frame_start is ignored in IDLE.
- Simultaneous events:
  - fade_start and frame_start in the same cycle: fade_start wins, and that frame_start is not counted.
  - fade_start during an active fade restarts with the new mode; no fade_done for the aborted fade.
- busy = (state != IDLE).
- transparent is index==0 piped alongside the data. It is independent of level and of the palette contents.

Test Plan:
- Reset, then index 0..15 with pix_valid=1 at full level:
  - Index 0: black with transparent=1, 2 cycles later.
  - Index 1..15: F,0,0 with transparent=0.
  - out_valid tracks pix_valid delayed 2 cycles.
- Write entry 5 = {A,5,3} while reading index 5 in the same cycle:
  - That read returns F,0,0.
  - The next cycle's read of index 5 returns A,5,3.
- Fade-in, STEP_FRAMES=4: fade_start mode 01, then 64 frame_start pulses.
  - level steps 0→16, one step per 4 frames; busy is high throughout.
  - Entry {A,5,3} at level 8 outputs 5,2,1.
  - fade_done pulses once on the 64th frame and busy drops in that same cycle.
- Blink: mode 11, then 12 frames.
  - Output alternates F,0,0 / 0,0,0 / F,0,0 every 4 frames.
  - fade_start with mode 00 restores full level immediately.
  - fade_done never asserts.
- fade_start coincident with frame_start:
  - That frame is not counted; the first step occurs after 4 further frames.
- Reset mid-fade (level 7, FADE_OUT):
  - The next cycle shows level 16, busy=0, palette at defaults, and no fade_done.

Source files
------------

// File: rtl/palette_fader.sv
// Writable colour palette with a 2-stage lookup/scale pipeline and a
// frame-synchronous brightness sequencer for fade-in, fade-out and blink.
module palette_fader #(
    parameter int unsigned INDEX_W     = 4,
    parameter int unsigned CH_W        = 4,
    parameter int unsigned STEP_FRAMES = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_start,
    input  logic                pix_valid,
    input  logic [INDEX_W-1:0]  index,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [3*CH_W-1:0]   wr_color,
    input  logic [1:0]          fade_mode,
    input  logic                fade_start,
    output logic [CH_W-1:0]     red,
    output logic [CH_W-1:0]     green,
    output logic [CH_W-1:0]     blue,
    output logic                out_valid,
    output logic                transparent,
    output logic                busy,
    output logic                fade_done
);
    localparam int unsigned ENTRIES = 1 << INDEX_W;
    localparam int unsigned COL_W   = 3 * CH_W;
    localparam int unsigned LVL_W   = CH_W + 1;
    localparam int unsigned PROD_W  = 2 * CH_W + 1;
    localparam int unsigned CNT_W   = 8;

    localparam logic [LVL_W-1:0] LVL_MAX   = LVL_W'(1 << CH_W);
    localparam logic [CH_W-1:0]  CH_MAX    = '1;
    localparam logic [COL_W-1:0] RED_ENTRY = {CH_MAX, (2*CH_W)'(0)};
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, FADE_IN, FADE_OUT, BLINK} state_e;

    logic [COL_W-1:0] pal_q [ENTRIES];
    logic [COL_W-1:0] pal_d [ENTRIES];
    logic [COL_W-1:0] s1_color_q, s1_color_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_transp_q, s1_transp_d;
    logic [CH_W-1:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic             out_valid_q, out_valid_d;
    logic             transparent_q, transparent_d;
    logic             busy_q, busy_d;
    logic             fade_done_q, fade_done_d;
    state_e           state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // out = (c * level) >> CH_W, truncated
    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c,
                                              input logic [LVL_W-1:0] lvl);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(c) * PROD_W'(lvl);
        return CH_W'(prod >> CH_W);
    endfunction

    // Palette write and the two pipeline stages; reads see the pre-write contents.
    always_comb begin
        pal_d = pal_q;
        if (wr_en) pal_d[wr_index] = wr_color;
        s1_color_d    = pal_q[index];
        s1_valid_d    = pix_valid;
        s1_transp_d   = (index == '0);
        red_d         = scale(s1_color_q[COL_W-1 -: CH_W], level_q);
        green_d       = scale(s1_color_q[2*CH_W-1 -: CH_W], level_q);
        blue_d        = scale(s1_color_q[CH_W-1 -: CH_W], level_q);
        out_valid_d   = s1_valid_q;
        transparent_d = s1_transp_q;
    end

    // Brightness sequencer; fade_start takes priority over frame counting.
    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        fade_done_d = 1'b0;
        if (fade_start) begin
            cnt_d = '0;
            unique case (fade_mode)
                2'b01:   begin level_d = '0;      state_d = FADE_IN;  end
                2'b10:   begin level_d = LVL_MAX; state_d = FADE_OUT; end
                2'b11:   begin level_d = LVL_MAX; state_d = BLINK;    end
                default: begin level_d = LVL_MAX; state_d = IDLE;     end
            endcase
        end else if (frame_start && state_q != IDLE) begin
            if (cnt_q == STEP_LAST) begin
                cnt_d = '0;
                unique case (state_q)
                    FADE_IN: begin
                        level_d = level_q + LVL_W'(1);
                        if (level_d == LVL_MAX) begin
                            state_d     = IDLE;
                            fade_done_d = 1'b1;
                        end
                    end
                    FADE_OUT: begin
                        level_d = level_q - LVL_W'(1);
                        if (level_d == '0) begin
                            state_d     = IDLE;
                            fade_done_d = 1'b1;
                        end
                    end
                    BLINK:   level_d = (level_q == LVL_MAX) ? '0 : LVL_MAX;
                    default: level_d = level_q;
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) pal_q[i] <= (i == 0) ? '0 : RED_ENTRY;
            s1_color_q    <= '0;
            s1_valid_q    <= 1'b0;
            s1_transp_q   <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            out_valid_q   <= 1'b0;
            transparent_q <= 1'b0;
            busy_q        <= 1'b0;
            fade_done_q   <= 1'b0;
            state_q       <= IDLE;
            level_q       <= LVL_MAX;
            cnt_q         <= '0;
        end else begin
            pal_q         <= pal_d;
            s1_color_q    <= s1_color_d;
            s1_valid_q    <= s1_valid_d;
            s1_transp_q   <= s1_transp_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            out_valid_q   <= out_valid_d;
            transparent_q <= transparent_d;
            busy_q        <= busy_d;
            fade_done_q   <= fade_done_d;
            state_q       <= state_d;
            level_q       <= level_d;
            cnt_q         <= cnt_d;
        end
    end

    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign out_valid   = out_valid_q;
    assign transparent = transparent_q;
    assign busy        = busy_q;
    assign fade_done   = fade_done_q;
endmodule

// File: tb/tb_palette_fader.sv
// Directed bench for palette_fader: pixel results go through a scoreboard queue,
// control outputs are checked directly one cycle after each driving edge.
module tb_palette_fader;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [3:0]  index = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_index = '0;
    logic [11:0] wr_color = '0;
    logic [1:0]  fade_mode = '0;
    logic        fade_start = 1'b0;
    logic [3:0]  red, green, blue;
    logic        out_valid, transparent, busy, fade_done;

    palette_fader #(.INDEX_W(4), .CH_W(4), .STEP_FRAMES(4)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .index(index), .wr_en(wr_en), .wr_index(wr_index), .wr_color(wr_color),
        .fade_mode(fade_mode), .fade_start(fade_start), .red(red), .green(green),
        .blue(blue), .out_valid(out_valid), .transparent(transparent), .busy(busy),
        .fade_done(fade_done)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;
    logic [12:0] sb_q[$];
    logic [11:0] pal_m [16];
    int lvl_m = 16;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] scl(input logic [3:0] c, input int lvl);
        return 4'((int'(c) * lvl) / 16);
    endfunction

    task automatic pal_defaults();
        for (int i = 0; i < 16; i++) pal_m[i] = (i == 0) ? 12'h000 : 12'hF00;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Drive one valid pixel for one cycle and record what it must produce.
    task automatic pix(input logic [3:0] idx);
        logic [11:0] c;
        c = pal_m[idx];
        pix_valid = 1'b1;
        index = idx;
        sb_q.push_back({scl(c[11:8], lvl_m), scl(c[7:4], lvl_m), scl(c[3:0], lvl_m),
                        (idx == 4'd0)});
        step();
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) step();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic start_fade(input logic [1:0] mode, input logic with_frame);
        fade_start = 1'b1;
        fade_mode = mode;
        frame_start = with_frame;
        step();
        fade_start = 1'b0;
        frame_start = 1'b0;
    endtask

    // Scoreboard: every out_valid must match the oldest outstanding pixel.
    always @(negedge Clk) begin
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                chk("pixel_rgbt", {red, green, blue, transparent}, sb_q.pop_front());
            end
        end
    end

    initial begin
        pal_defaults();
        step();
        step();
        chk("rst_rgb", {red, green, blue}, 0);
        chk("rst_flags", {out_valid, transparent, busy, fade_done}, 0);
        Reset = 1'b0;

        // Default palette at full brightness, back-to-back pixels.
        for (int i = 0; i < 16; i++) pix(4'(i));
        drain();
        chk("sweep_drained", sb_q.size(), 0);

        // Same-cycle write/read returns old value; next cycle sees new one.
        wr_en = 1'b1;
        wr_index = 4'd5;
        wr_color = 12'hA53;
        pix(4'd5);
        wr_en = 1'b0;
        pal_m[5] = 12'hA53;
        pix(4'd5);
        drain();

        // Fade-in: one step per 4 frames, 16 steps.
        start_fade(2'b01, 1'b0);
        lvl_m = 0;
        chk("fin_busy_start", busy, 1);
        pix(4'd5);
        drain();
        for (int f = 1; f <= 64; f++) begin
            frame();
            lvl_m = f / 4;
            chk("fin_busy", busy, (f < 64) ? 1 : 0);
            chk("fin_done", fade_done, (f == 64) ? 1 : 0);
            if (f % 8 == 0 || f == 4) begin
                pix(4'd5);
                step();
            end
        end
        step();
        chk("fin_done_pulse_once", fade_done, 0);
        drain();

        // Blink toggles full/zero every 4 frames; mode 00 restores full level.
        start_fade(2'b11, 1'b0);
        lvl_m = 16;
        pix(4'd1);
        step();
        for (int f = 1; f <= 12; f++) begin
            frame();
            if (f % 4 == 0) lvl_m = (lvl_m == 16) ? 0 : 16;
            chk("blink_busy", busy, 1);
            chk("blink_no_done", fade_done, 0);
            pix(4'd1);
            step();
        end
        start_fade(2'b00, 1'b0);
        lvl_m = 16;
        chk("stop_busy", busy, 0);
        chk("stop_no_done", fade_done, 0);
        pix(4'd1);
        drain();

        // Fade-out started together with a frame pulse: that frame is not counted.
        start_fade(2'b10, 1'b1);
        lvl_m = 16;
        for (int f = 1; f <= 3; f++) frame();
        pix(4'd1);
        step();
        frame();
        lvl_m = 15;
        pix(4'd1);
        step();
        for (int f = 5; f <= 36; f++) begin
            frame();
            chk("fout_no_done", fade_done, 0);
        end
        lvl_m = 7;
        pix(4'd1);
        pix(4'd5);
        drain();
        chk("fout_busy_l7", busy, 1);

        // Reset mid-fade: defaults back, nothing pending, no completion pulse.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", fade_done, 0);
        pal_defaults();
        lvl_m = 16;
        pix(4'd5);
        pix(4'd0);
        drain();

        // Frames in IDLE do nothing.
        for (int f = 0; f < 8; f++) begin
            frame();
            chk("idle_frame_done", fade_done, 0);
            chk("idle_frame_busy", busy, 0);
        end
        pix(4'd3);
        drain();
        chk("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
